// File: rtl/sdf_stage_ctrl_if.sv
// Handshake and status bundle between an SDF stage sequencer and its host.
// The master drives input-side controls; the slave is the stage controller.
interface sdf_stage_ctrl_if #(
  parameter int ADDR_W = 4
);
  logic              in_valid;
  logic              in_sop;
  logic              in_ready;
  logic              flush;
  logic              bf_sel;
  logic [ADDR_W-1:0] tw_addr;
  logic              tw_valid;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic              frame_err;
  logic              busy;

  modport master (
    output in_valid, in_sop, flush,
    input  in_ready, bf_sel, tw_addr, tw_valid,
    input  out_valid, out_sop, out_eop, frame_err, busy
  );

  modport slave (
    input  in_valid, in_sop, flush,
    output in_ready, bf_sel, tw_addr, tw_valid,
    output out_valid, out_sop, out_eop, frame_err, busy
  );
endinterface

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 DIF single-path delay-feedback FFT stage:
// sample counting, butterfly select, twiddle ROM addressing and output framing.
module sdf_stage_ctrl #(
  parameter int N_POINTS = 16,
  parameter int ADDR_W   = 4,
  parameter int PIPE_LAT = 1
) (
  input logic             clk,
  input logic             rst,
  sdf_stage_ctrl_if.slave bus
);
  localparam int               CNT_W   = $clog2(N_POINTS);
  localparam logic [CNT_W-1:0] HALF    = CNT_W'(N_POINTS / 2);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(N_POINTS / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_RUN, ST_DRAIN} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             flush_pend_reg;
  logic             frame_err_reg;
  // Each stage holds {valid, sop, eop} of one tick.
  logic [2:0]       pipe_reg [PIPE_LAT];

  logic cnt_zero;
  logic drain_req;
  logic ready;
  logic tick;
  logic resync;
  logic emit;
  logic emit_sop;
  logic emit_eop;
  logic bf_sel;

  always_comb begin
    cnt_zero  = (cnt_reg == '0);
    // A pending flush takes effect only on a frame boundary and beats in_valid there.
    drain_req = (state_reg == ST_RUN) && cnt_zero && (bus.flush || flush_pend_reg);
    ready     = !rst && (state_reg != ST_DRAIN) && !drain_req;
    tick      = 1'b0;
    if (!rst) begin
      case (state_reg)
        ST_IDLE:  tick = ready && bus.in_valid && bus.in_sop && !bus.flush;
        ST_PRIME: tick = ready && bus.in_valid && !bus.flush;
        ST_RUN:   tick = ready && bus.in_valid;
        ST_DRAIN: tick = 1'b1;
        default:  tick = 1'b0;
      endcase
    end
    resync   = tick && bus.in_sop && !cnt_zero &&
               ((state_reg == ST_PRIME) || (state_reg == ST_RUN));
    // A resync tick starts a new frame, so it never contributes an output sample.
    emit     = tick && (((state_reg == ST_RUN) && !resync) || (state_reg == ST_DRAIN));
    emit_sop = emit && (state_reg == ST_RUN) && (cnt_reg == HALF);
    emit_eop = emit && (cnt_reg == HALF_M1);
    bf_sel   = !rst && cnt_reg[CNT_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      flush_pend_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      frame_err_reg <= resync;
      case (state_reg)
        ST_IDLE: begin
          if (bus.flush) begin
            cnt_reg        <= '0;
            flush_pend_reg <= 1'b0;
          end else if (tick) begin
            cnt_reg   <= CNT_W'(1);
            state_reg <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (bus.flush) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            flush_pend_reg <= 1'b0;
          end else if (resync) begin
            cnt_reg <= CNT_W'(1);
          end else if (tick) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == HALF_M1) state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (drain_req) begin
            state_reg      <= ST_DRAIN;
            flush_pend_reg <= 1'b0;
          end else begin
            if (bus.flush) flush_pend_reg <= 1'b1;
            if (resync) begin
              cnt_reg   <= CNT_W'(1);
              state_reg <= ST_PRIME;
            end else if (tick) begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (cnt_reg == HALF_M1) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  // Framing delay matches the twiddle ROM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) pipe_reg[i] <= '0;
    end else begin
      pipe_reg[0] <= {emit, emit_sop, emit_eop};
      for (int i = 1; i < PIPE_LAT; i++) pipe_reg[i] <= pipe_reg[i-1];
    end
  end

  assign bus.in_ready  = ready;
  assign bus.bf_sel    = bf_sel;
  assign bus.tw_addr   = (rst || bf_sel) ? '0 : ADDR_W'(cnt_reg[CNT_W-2:0]);
  assign bus.tw_valid  = tick;
  assign bus.out_valid = pipe_reg[PIPE_LAT-1][2] && !rst;
  assign bus.out_sop   = pipe_reg[PIPE_LAT-1][1] && !rst;
  assign bus.out_eop   = pipe_reg[PIPE_LAT-1][0] && !rst;
  assign bus.frame_err = frame_err_reg && !rst;
  assign bus.busy      = (state_reg != ST_IDLE) && !rst;
endmodule
